led_pwm_panel: RTL and testbench



---
 rtl/led_pwm_panel.sv | 234 +++++++++++++++++++++++
 tb/tb_led_pwm_panel.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_panel.sv
// led_pwm_panel -- memory-mapped LED output panel for the CPU6 data bus.
//
// Up to 16 channels, each with an enable bit, a PWM duty register and a
// blink enable. The CPU sees a 32-byte window at BASE_ADDR:
//   0 OUT_LO   1 OUT_HI   2 BLINK_LO   3 BLINK_HI
//   4 CTRL     {half_period_minus_1[7:4], 3'b0, global_en[0]}
//   5 STATUS   {7'b0, blink_phase}
//   8..8+CHANNELS-1  DUTY[n] (low PWM_BITS bits)
// Reads are registered: data_out/selected are valid one cycle after the
// address is presented, and both are 0 on any cycle without a read hit, so
// the top level can simply OR or mux this block against RAM.
//
// Ports:
//   clock     system clock, rising edge
//   reset     asynchronous active-low reset
//   address   CPU address bus
//   writeEn   CPU write strobe
//   data_in   CPU write data
//   data_out  registered read data (0 when not selected)
//   selected  high the cycle data_out carries a read from this block
//   leds      registered channel outputs

// One output channel: its duty register, PWM compare and output flop.
module led_pwm_lane #(
  parameter int PWM_BITS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                duty_we,
  input  logic [PWM_BITS-1:0] duty_wdata,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                gate,      // enable & out & blink qualifier
  output logic [PWM_BITS-1:0] duty,
  output logic                led
);
  logic pwm_on;

  // All-ones is forced on so full brightness has no one-cycle gap per period.
  assign pwm_on = (&duty) | (pwm_cnt < duty);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      duty <= '1;
      led  <= 1'b0;
    end else begin
      if (duty_we) duty <= duty_wdata;
      led <= gate & pwm_on;
    end
  end
endmodule

module led_pwm_panel #(
  parameter logic [15:0] BASE_ADDR = 16'hF200,
  parameter int          CHANNELS  = 8,
  parameter int          PWM_BITS  = 4,
  parameter int          PRESCALE  = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [15:0]         address,
  input  logic                writeEn,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  output logic                selected,
  output logic [CHANNELS-1:0] leds
);
  localparam int PS_W = $clog2(PRESCALE);

  // Register offsets
  localparam logic [4:0] OFF_OUT_LO   = 5'd0;
  localparam logic [4:0] OFF_OUT_HI   = 5'd1;
  localparam logic [4:0] OFF_BLINK_LO = 5'd2;
  localparam logic [4:0] OFF_BLINK_HI = 5'd3;
  localparam logic [4:0] OFF_CTRL     = 5'd4;
  localparam logic [4:0] OFF_STATUS   = 5'd5;
  localparam logic [4:0] OFF_DUTY0    = 5'd8;

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic       hit, bus_wr, bus_rd, ctrl_wr;
  logic [4:0] off;

  assign hit     = (address[15:5] == BASE_ADDR[15:5]);
  assign off     = address[4:0];
  assign bus_wr  = hit & writeEn;
  assign bus_rd  = hit & ~writeEn;
  assign ctrl_wr = bus_wr & (off == OFF_CTRL);

  // ---------------------------------------------------------------------
  // Control / channel state
  // ---------------------------------------------------------------------
  logic [CHANNELS-1:0] out_q, blink_q;
  logic                ctrl_en;
  logic [3:0]          ctrl_half;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PS_W-1:0]     prescaler;
  logic [3:0]          blink_cnt;
  logic                blink_phase;
  logic                tick;

  logic [CHANNELS-1:0][PWM_BITS-1:0] duty;

  // Channel vectors widened to the full 16-bit register pair. Bits above
  // CHANNELS stay 0 so they read back as 0 and are dropped on write.
  logic [15:0] out_ext, blink_ext, out_wr, blink_wr;
  logic [15:0][7:0] duty_ext;

  always_comb begin
    out_ext   = '0;
    blink_ext = '0;
    duty_ext  = '0;
    out_ext[CHANNELS-1:0]   = out_q;
    blink_ext[CHANNELS-1:0] = blink_q;
    for (int n = 0; n < CHANNELS; n++) duty_ext[n] = 8'(duty[n]);
  end

  // Byte-lane merge of a write into the 16-bit views.
  always_comb begin
    out_wr   = out_ext;
    blink_wr = blink_ext;
    if (off == OFF_OUT_LO)   out_wr[7:0]    = data_in;
    if (off == OFF_OUT_HI)   out_wr[15:8]   = data_in;
    if (off == OFF_BLINK_LO) blink_wr[7:0]  = data_in;
    if (off == OFF_BLINK_HI) blink_wr[15:8] = data_in;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_q     <= '0;
      blink_q   <= '0;
      ctrl_en   <= 1'b1;
      ctrl_half <= '0;
    end else if (bus_wr) begin
      if (off == OFF_OUT_LO || off == OFF_OUT_HI)
        out_q <= out_wr[CHANNELS-1:0];
      if (off == OFF_BLINK_LO || off == OFF_BLINK_HI)
        blink_q <= blink_wr[CHANNELS-1:0];
      if (off == OFF_CTRL) begin
        ctrl_en   <= data_in[0];
        ctrl_half <= data_in[7:4];
      end
    end
  end

  // ---------------------------------------------------------------------
  // PWM and blink timebase
  // ---------------------------------------------------------------------
  assign tick = (prescaler == PS_W'(PRESCALE - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pwm_cnt     <= '0;
      prescaler   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (ctrl_wr) begin
        // Restart the blink pattern so a new period starts in the on phase.
        prescaler   <= '0;
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else begin
        prescaler <= tick ? '0 : prescaler + 1'b1;
        if (tick) begin
          if (blink_cnt == ctrl_half) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Channel lanes
  // ---------------------------------------------------------------------
  for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
    logic gate;
    logic duty_we;

    assign gate    = ctrl_en & out_q[n] & (~blink_q[n] | blink_phase);
    assign duty_we = bus_wr & (off == 5'(8 + n));

    led_pwm_lane #(.PWM_BITS(PWM_BITS)) u_lane (
      .clock      (clock),
      .reset      (reset),
      .duty_we    (duty_we),
      .duty_wdata (data_in[PWM_BITS-1:0]),
      .pwm_cnt    (pwm_cnt),
      .gate       (gate),
      .duty       (duty[n]),
      .led        (leds[n])
    );
  end

  // ---------------------------------------------------------------------
  // Read-back
  // ---------------------------------------------------------------------
  logic [7:0] rdata;
  logic [4:0] didx;

  assign didx = off - OFF_DUTY0;

  always_comb begin
    rdata = '0;
    case (off)
      OFF_OUT_LO:   rdata = out_ext[7:0];
      OFF_OUT_HI:   rdata = out_ext[15:8];
      OFF_BLINK_LO: rdata = blink_ext[7:0];
      OFF_BLINK_HI: rdata = blink_ext[15:8];
      OFF_CTRL:     rdata = {ctrl_half, 3'b000, ctrl_en};
      OFF_STATUS:   rdata = {7'b0, blink_phase};
      default: begin
        // Offsets 8..23 map onto the 16 duty slots; unused slots read 0.
        if (off >= OFF_DUTY0 && off < 5'd24) rdata = duty_ext[didx[3:0]];
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      selected <= 1'b0;
    end else begin
      selected <= bus_rd;
      data_out <= bus_rd ? rdata : 8'h00;
    end
  end
endmodule

// File: tb/tb_led_pwm_panel.sv
module tb_led_pwm_panel;
  localparam logic [15:0] BASE = 16'hF200;
  localparam int CH   = 8;
  localparam int PW   = 4;
  localparam int PS   = 4;
  localparam int DMAX = (1 << PW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [15:0]   address;
  logic          writeEn;
  logic [7:0]    data_in;
  logic [7:0]    data_out;
  logic          selected;
  logic [CH-1:0] leds;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  led_pwm_panel #(.BASE_ADDR(BASE), .CHANNELS(CH), .PWM_BITS(PW), .PRESCALE(PS)) dut (
    .clock(clock), .reset(reset), .address(address), .writeEn(writeEn),
    .data_in(data_in), .data_out(data_out), .selected(selected), .leds(leds)
  );

  function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------------------------------------------------------------
  // Reference model: register file and timebase as plain integers.
  // ---------------------------------------------------------------------
  typedef struct {
    logic          sel;
    logic [7:0]    data;
    logic [CH-1:0] leds;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] m_out, m_blink;
  bit          m_en, m_phase;
  int          m_half, m_pwm, m_presc, m_bcnt;
  int          m_duty[16];

  function automatic void m_reset();
    m_out = 0; m_blink = 0; m_en = 1; m_half = 0;
    m_pwm = 0; m_presc = 0; m_bcnt = 0; m_phase = 1;
    for (int i = 0; i < 16; i++) m_duty[i] = DMAX;
  endfunction

  function automatic logic [7:0] m_read(int off);
    case (off)
      0: return m_out[7:0];
      1: return m_out[15:8];
      2: return m_blink[7:0];
      3: return m_blink[15:8];
      4: return 8'(m_half * 16 + (m_en ? 1 : 0));
      5: return m_phase ? 8'h01 : 8'h00;
      default: return (off >= 8 && off < 8 + CH) ? 8'(m_duty[off-8]) : 8'h00;
    endcase
  endfunction

  function automatic logic [CH-1:0] m_leds();
    logic [CH-1:0] r = '0;
    for (int n = 0; n < CH; n++)
      r[n] = m_en && m_out[n] && (m_duty[n] == DMAX || m_pwm < m_duty[n])
             && (!m_blink[n] || m_phase);
    return r;
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_reset();
        sbq.delete();
      end else begin
        exp_t e;
        int   off;
        bit   hit;
        off   = int'(address) - int'(BASE);
        hit   = (off >= 0) && (off < 32);
        e.leds = m_leds();
        e.sel  = hit && !writeEn;
        e.data = e.sel ? m_read(off) : 8'h00;
        sbq.push_back(e);
        m_pwm = (m_pwm + 1) % (DMAX + 1);
        if (hit && writeEn && off == 4) begin
          m_en = data_in[0]; m_half = int'(data_in[7:4]);
          m_presc = 0; m_bcnt = 0; m_phase = 1;
        end else begin
          if (m_presc == PS - 1) begin
            m_presc = 0;
            if (m_bcnt == m_half) begin m_bcnt = 0; m_phase = !m_phase; end
            else m_bcnt++;
          end else m_presc++;
          if (hit && writeEn) begin
            case (off)
              0: m_out[7:0]    = data_in;
              1: m_out[15:8]   = data_in;
              2: m_blink[7:0]  = data_in;
              3: m_blink[15:8] = data_in;
              default: if (off >= 8 && off < 8 + CH) m_duty[off-8] = int'(data_in) % (DMAX + 1);
            endcase
            m_out   &= 16'((1 << CH) - 1);
            m_blink &= 16'((1 << CH) - 1);
          end
        end
      end
    end
  end

  // Monitor: one expected entry per clock, checked on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (reset && sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_selected", 16'(selected), 16'(e.sel));
        chk("sb_data_out", 16'(data_out), 16'(e.data));
        chk("sb_leds",     16'(leds),     16'(e.leds));
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    address = a; data_in = d; writeEn = 1'b1;
    @(negedge clock);
    writeEn = 1'b0; address = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] a);
    address = a; writeEn = 1'b0;
    @(negedge clock);
    address = 16'h0000;
  endtask

  task automatic rdc(input string nm, input logic [15:0] a, input logic s, input logic [7:0] d);
    rd(a);
    chk({nm, "_sel"}, 16'(selected), 16'(s));
    chk({nm, "_data"}, 16'(data_out), 16'(d));
  endtask

  task automatic count_hi(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clock);
      if (leds[0]) c++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, w, last, ntog;
    int tog[$];
    logic prev;
    reset = 1'b0; address = 16'h0000; writeEn = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst_leds", 16'(leds), 16'h0);
    chk("rst_sel", 16'(selected), 16'h0);
    #2 reset = 1'b1;

    // 1: reset values
    idle(3);
    chk("t1_leds", 16'(leds), 16'h0);
    rdc("t1_ctrl", BASE + 16'd4, 1'b1, 8'h01);
    rdc("t1_duty0", BASE + 16'd8, 1'b1, 8'h0F);

    // 2: OUT_LO write/read, steady leds, OUT_HI has no channels
    wr(BASE, 8'hA5);
    rdc("t2_outlo", BASE, 1'b1, 8'hA5);
    chk("t2_leds", 16'(leds), 16'h00A5);
    c = 0;
    repeat (64) begin @(negedge clock); if (leds == 8'hA5) c++; end
    chk("t2_steady", 16'(c), 16'd64);
    wr(BASE + 16'd1, 8'hFF);
    rdc("t2_outhi", BASE + 16'd1, 1'b1, 8'h00);

    // 3: PWM duty
    wr(BASE + 16'd8, 8'h04);
    wr(BASE, 8'h01);
    idle(2);
    count_hi(16, c); chk("t3_duty4", 16'(c), 16'd4);
    count_hi(16, c); chk("t3_duty4b", 16'(c), 16'd4);
    wr(BASE + 16'd8, 8'h00); idle(2);
    count_hi(32, c); chk("t3_duty0", 16'(c), 16'd0);
    wr(BASE + 16'd8, 8'h0F); idle(2);
    count_hi(32, c); chk("t3_duty15", 16'(c), 16'd32);

    // 4: blink, half period 3 ticks of 4 clocks
    wr(BASE + 16'd2, 8'h01);
    wr(BASE + 16'd4, 8'h21);
    rdc("t4_ctrl", BASE + 16'd4, 1'b1, 8'h21);
    prev = leds[0]; last = 0; ntog = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clock);
      if (leds[0] !== prev) tog.push_back(i);
      prev = leds[0];
    end
    chk("t4_ntog", 16'(tog.size() >= 4), 16'd1);
    for (int i = 1; i < tog.size() && i < 5; i++)
      chk("t4_interval", 16'(tog[i] - tog[i-1]), 16'd12);

    // 5: window edges
    rdc("t5_top", BASE + 16'd31, 1'b1, 8'h00);
    rdc("t5_below", BASE - 16'd1, 1'b0, 8'h00);
    wr(BASE + 16'd32, 8'hFF);
    rdc("t5_noalias", BASE, 1'b1, 8'h01);
    rdc("t5_status0", BASE + 16'd6, 1'b1, 8'h00);

    // 6: async reset mid-blink with a write pending
    w = 0;
    while (!leds[0] && w < 40) begin @(negedge clock); w++; end
    chk("t6_led_on", 16'(w < 40), 16'd1);
    address = BASE; data_in = 8'hFF; writeEn = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("t6_async_leds", 16'(leds), 16'h0);
    chk("t6_async_sel", 16'(selected), 16'h0);
    @(negedge clock);
    writeEn = 1'b0; address = 16'h0000;
    #2 reset = 1'b1;
    rdc("t6_out", BASE, 1'b1, 8'h00);
    rdc("t6_blink", BASE + 16'd2, 1'b1, 8'h00);
    rdc("t6_ctrl", BASE + 16'd4, 1'b1, 8'h01);
    rdc("t6_status", BASE + 16'd5, 1'b1, 8'h01);
    rdc("t6_duty", BASE + 16'd8, 1'b1, 8'h0F);

    // Randomized traffic checked through the scoreboard
    for (int i = 0; i < 1500; i++) begin
      int k;
      logic [15:0] a;
      logic [7:0]  d;
      k = $urandom_range(0, 9);
      a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : BASE + 16'($urandom_range(0, 31));
      if (k < 2) a = BASE + 16'($urandom_range(0, 3));
      d = 8'($urandom);
      if (a == BASE + 16'd4) begin
        d[0] = ($urandom_range(0, 3) != 0);
        d[7:6] = 2'b00;
      end
      if (k < 4) idle(1);
      else if (k < 7) rd(a);
      else wr(a, d);
    end
    idle(4);
    chk("sb_drained", 16'(sbq.size() <= 1), 16'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
